// File: rtl/mcu_program_loader.sv
// Byte-stream boot loader: parses SYNC/addr/count/data/checksum frames, writes the
// MCU instruction memory and releases the MCU from reset once the image is verified.
module mcu_program_loader #(
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  i_reload,
  input  logic [7:0]            i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_imem_we,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic [7:0]            o_imem_wdata,
  output logic                  o_mcu_reset,
  output logic [ADDR_WIDTH-1:0] o_mcu_resetPC,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  localparam int unsigned CNT_W = 9;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_COUNT = 3'd2,
    S_DATA  = 3'd3,
    S_CHECK = 3'd4,
    S_RUN   = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [CNT_W-1:0]      r_rem;
  logic [7:0]            r_sum;

  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_ptr_nxt;
  logic [CNT_W-1:0]      w_rem_nxt;
  logic [7:0]            w_sum_nxt;
  logic                  w_we_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [7:0]            w_wdata_nxt;
  logic [ADDR_WIDTH-1:0] w_pc_nxt;
  logic                  w_ready_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;
  logic                  w_error_nxt;
  logic                  w_mcu_reset_nxt;
  logic                  w_xfer;
  logic [7:0]            w_sum_add;

  assign w_xfer    = i_valid && o_ready;
  assign w_sum_add = r_sum + i_data;

  // State and datapath registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_rem         <= '0;
      r_sum         <= '0;
      o_ready       <= 1'b1;
      o_imem_we     <= 1'b0;
      o_imem_addr   <= '0;
      o_imem_wdata  <= '0;
      o_mcu_reset   <= 1'b1;
      o_mcu_resetPC <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_rem         <= w_rem_nxt;
      r_sum         <= w_sum_nxt;
      o_ready       <= w_ready_nxt;
      o_imem_we     <= w_we_nxt;
      o_imem_addr   <= w_addr_nxt;
      o_imem_wdata  <= w_wdata_nxt;
      o_mcu_reset   <= w_mcu_reset_nxt;
      o_mcu_resetPC <= w_pc_nxt;
      o_busy        <= w_busy_nxt;
      o_done        <= w_done_nxt;
      o_error       <= w_error_nxt;
    end
  end

  // Next-state and next-output logic; reload wins over a simultaneous byte
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_rem_nxt   = r_rem;
    w_sum_nxt   = r_sum;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = o_imem_addr;
    w_wdata_nxt = o_imem_wdata;
    w_pc_nxt    = o_mcu_resetPC;

    if (i_reload) begin
      w_state_nxt = S_IDLE;
    end else if (w_xfer) begin
      case (r_state)
        S_IDLE: begin
          if (i_data == SYNC_BYTE) w_state_nxt = S_ADDR;
        end
        S_ADDR: begin
          w_ptr_nxt   = ADDR_WIDTH'(i_data);
          w_pc_nxt    = ADDR_WIDTH'(i_data);
          w_sum_nxt   = 8'h00;
          w_state_nxt = S_COUNT;
        end
        S_COUNT: begin
          // A zero count encodes a full 256-byte block
          w_rem_nxt   = (i_data == 8'h00) ? CNT_W'(256) : CNT_W'(i_data);
          w_state_nxt = S_DATA;
        end
        S_DATA: begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_ptr;
          w_wdata_nxt = i_data;
          w_ptr_nxt   = r_ptr + ADDR_WIDTH'(1);
          w_sum_nxt   = w_sum_add;
          w_rem_nxt   = r_rem - CNT_W'(1);
          if (r_rem == CNT_W'(1)) w_state_nxt = S_CHECK;
        end
        S_CHECK: begin
          w_state_nxt = (w_sum_add == 8'h00) ? S_RUN : S_ERROR;
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end

    // Status outputs are a pure function of the state being entered
    w_ready_nxt     = (w_state_nxt != S_RUN) && (w_state_nxt != S_ERROR);
    w_busy_nxt      = (w_state_nxt == S_ADDR) || (w_state_nxt == S_COUNT) ||
                      (w_state_nxt == S_DATA) || (w_state_nxt == S_CHECK);
    w_done_nxt      = (w_state_nxt == S_RUN);
    w_error_nxt     = (w_state_nxt == S_ERROR);
    w_mcu_reset_nxt = (w_state_nxt != S_RUN);
  end

endmodule

// File: tb/tb_mcu_program_loader.sv
// Scoreboard bench for mcu_program_loader: expected memory writes are queued as data
// bytes are sent and popped by a monitor when the write port fires.
module tb_mcu_program_loader;

  logic       Clk;
  logic       Reset;
  logic       i_reload;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       o_imem_we;
  logic [7:0] o_imem_addr;
  logic [7:0] o_imem_wdata;
  logic       o_mcu_reset;
  logic [7:0] o_mcu_resetPC;
  logic       o_busy;
  logic       o_done;
  logic       o_error;

  int n_checks = 0;
  int n_pass   = 0;
  int n_wr     = 0;
  logic [15:0] exp_q[$];

  mcu_program_loader #(.SYNC_BYTE(8'hA5), .ADDR_WIDTH(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .i_reload     (i_reload),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .o_mcu_reset  (o_mcu_reset),
    .o_mcu_resetPC(o_mcu_resetPC),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Monitor: every write must match the oldest outstanding expectation
  always @(negedge Clk) begin
    if (o_imem_we === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", {o_imem_addr, o_imem_wdata}, 32'hFFFF_FFFF);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check_eq("write_addr", o_imem_addr, e[15:8]);
        check_eq("write_data", o_imem_wdata, e[7:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    i_data  = b;
    i_valid = 1'b1;
    while (o_ready !== 1'b1 && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    if (n >= 20) check_eq("ready_timeout", o_ready, 1);
    @(posedge Clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] addr, input logic [7:0] b);
    exp_q.push_back({addr, b});
    send_byte(b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
    end
  endtask

  task automatic pulse_reload();
    i_reload = 1'b1;
    @(posedge Clk); #1;
    i_reload = 1'b0;
  endtask

  initial begin
    int base;
    Reset    = 1'b0;
    i_reload = 1'b0;
    i_data   = 8'h00;
    i_valid  = 1'b0;
    #100;
    Reset = 1'b1;
    @(posedge Clk); #1;
    check_eq("rst_mcu_reset", o_mcu_reset, 1);
    check_eq("rst_ready", o_ready, 1);
    check_eq("rst_done", o_done, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_error", o_error, 0);
    check_eq("rst_pc", o_mcu_resetPC, 8'h00);
    check_eq("rst_we", o_imem_we, 0);

    // Basic frame
    send_byte(8'hA5);
    check_eq("busy_after_sync", o_busy, 1);
    send_byte(8'h10);
    send_byte(8'h03);
    send_data(8'h10, 8'h11);
    send_data(8'h11, 8'h22);
    send_data(8'h12, 8'h33);
    check_eq("pre_check_done", o_done, 0);
    send_byte(8'h9A);
    check_eq("f1_done", o_done, 1);
    check_eq("f1_mcu_reset", o_mcu_reset, 0);
    check_eq("f1_pc", o_mcu_resetPC, 8'h10);
    check_eq("f1_busy", o_busy, 0);
    check_eq("f1_ready", o_ready, 0);

    // Bad checksum
    pulse_reload();
    check_eq("reload_mcu_reset", o_mcu_reset, 1);
    check_eq("reload_done", o_done, 0);
    check_eq("reload_pc_hold", o_mcu_resetPC, 8'h10);
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
    send_data(8'h10, 8'h11);
    send_data(8'h11, 8'h22);
    send_data(8'h12, 8'h33);
    send_byte(8'h9B);
    check_eq("f2_error", o_error, 1);
    check_eq("f2_mcu_reset", o_mcu_reset, 1);
    check_eq("f2_ready", o_ready, 0);
    check_eq("f2_done", o_done, 0);
    idle(2);
    check_eq("f2_error_sticky", o_error, 1);
    pulse_reload();
    check_eq("f2_reload_error", o_error, 0);
    check_eq("f2_reload_ready", o_ready, 1);

    // Junk before sync, address wrap
    send_byte(8'h00); send_byte(8'hFF);
    check_eq("junk_busy", o_busy, 0);
    send_byte(8'hA5); send_byte(8'hFE); send_byte(8'h03);
    send_data(8'hFE, 8'h01);
    send_data(8'hFF, 8'h02);
    send_data(8'h00, 8'h03);
    send_byte(8'hFA);
    check_eq("f3_done", o_done, 1);
    check_eq("f3_pc", o_mcu_resetPC, 8'hFE);

    // Full 256-byte block with wrap
    pulse_reload();
    base = n_wr;
    send_byte(8'hA5); send_byte(8'h40); send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_data(8'(8'h40 + i), 8'h01);
    idle(1);
    check_eq("f4_writes", n_wr - base, 256);
    check_eq("f4_done_early", o_done, 0);
    check_eq("f4_busy", o_busy, 1);
    send_byte(8'h00);
    check_eq("f4_done", o_done, 1);
    check_eq("f4_pc", o_mcu_resetPC, 8'h40);

    // Reload colliding with second data byte
    pulse_reload();
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'h03);
    send_data(8'h20, 8'h44);
    i_data = 8'h55; i_valid = 1'b1; i_reload = 1'b1;
    @(posedge Clk); #1;
    i_reload = 1'b0; i_valid = 1'b0;
    check_eq("rl_we", o_imem_we, 0);
    check_eq("rl_busy", o_busy, 0);
    check_eq("rl_mcu_reset", o_mcu_reset, 1);
    check_eq("rl_ready", o_ready, 1);
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'h02);
    send_data(8'h20, 8'h55);
    send_data(8'h21, 8'h66);
    send_byte(8'h45);
    check_eq("rl_f_done", o_done, 1);
    check_eq("rl_f_pc", o_mcu_resetPC, 8'h20);

    // Asynchronous reset mid-data
    pulse_reload();
    send_byte(8'hA5); send_byte(8'h30); send_byte(8'h04);
    send_data(8'h30, 8'h01);
    send_data(8'h31, 8'h02);
    idle(1);
    #2;
    Reset = 1'b0;
    #1;
    check_eq("ar_we", o_imem_we, 0);
    check_eq("ar_mcu_reset", o_mcu_reset, 1);
    check_eq("ar_busy", o_busy, 0);
    check_eq("ar_pc", o_mcu_resetPC, 8'h00);
    check_eq("ar_ready", o_ready, 1);
    check_eq("ar_addr", o_imem_addr, 8'h00);
    idle(2);
    Reset = 1'b1;
    idle(1);

    // Gapped valid after reset
    send_byte(8'hA5); idle(1);
    send_byte(8'h30); idle(2);
    send_byte(8'h03);
    send_data(8'h30, 8'h07); idle(1);
    send_data(8'h31, 8'h08); idle(3);
    send_data(8'h32, 8'h09); idle(1);
    check_eq("gap_done_early", o_done, 0);
    send_byte(8'hE8);
    check_eq("gap_done", o_done, 1);
    check_eq("gap_mcu_reset", o_mcu_reset, 0);
    idle(2);
    check_eq("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mcu_program_loader.md
Name: mcu_program_loader

Overview:
- Byte-stream boot loader that writes a program image into the 8-bit MCU's instruction memory; it is the writer side of the memory the MCU core fetches from.
- Holds the MCU in reset while loading, validates a checksum, then releases reset with the loaded start address as resetPC.
- Sits between a host byte source (UART receiver or testbench) and the mcu_8bit Reset/resetPC inputs plus the instruction-memory write port.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker
- ADDR_WIDTH, 8, instruction-memory address width (matches 8-bit PC)

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- i_reload  in  1  single-cycle pulse: abort/restart loading, MCU back into reset
- i_data  in  8  incoming stream byte
- i_valid  in  1  i_data valid
- o_ready  out  1  loader can accept a byte; transfer when i_valid && o_ready at rising edge
- o_imem_we  out  1  instruction-memory write enable, one cycle per data byte
- o_imem_addr  out  ADDR_WIDTH  write address
- o_imem_wdata  out  8  write data
- o_mcu_reset  out  1  active-high reset to mcu_8bit Reset
- o_mcu_resetPC  out  ADDR_WIDTH  start address to mcu_8bit resetPC
- o_busy  out  1  frame in progress (states ADDR..CHECK)
- o_done  out  1  image loaded and verified, MCU running
- o_error  out  1  checksum mismatch, sticky

Behaviour:
- Reset asserted (low): state=S_IDLE, o_ready=1, o_imem_we=0, o_imem_addr=0, o_imem_wdata=0, o_mcu_reset=1, o_mcu_resetPC=0, o_busy=0, o_done=0, o_error=0, internal pointer/count/sum=0.
- Frame format: SYNC_BYTE, start address A, count N (N=0 means 256), N data bytes, checksum C.
- Valid frame: (sum of data bytes + C) mod 256 == 0.
- All outputs registered. Each state advances only on an accepted byte.
- S_IDLE: o_ready=1. A byte == SYNC_BYTE goes to S_ADDR. Any other byte is discarded, state unchanged.
- S_ADDR: latch A into the pointer and into o_mcu_resetPC; clear sum; go to S_COUNT.
- S_COUNT: latch N into a 9-bit remaining count (0 loads 256); go to S_DATA.
- S_DATA, per accepted byte:
  - On the same edge, register o_imem_we=1, o_imem_addr=pointer, o_imem_wdata=byte. The write is visible the next cycle (latency 1).
  - pointer+1 with wrap 0xFF->0x00; sum+=byte mod 256; remaining-1.
  - When remaining reaches 0, go to S_CHECK.
  - o_imem_we returns to 0 on any edge without an accepted data byte.
- S_CHECK, on the accepted checksum byte:
  - Match: go to S_RUN. On the same edge o_mcu_reset<=0, o_done<=1, o_busy<=0.
  - Mismatch: go to S_ERROR with o_error<=1. o_mcu_reset stays 1.
- S_RUN: o_ready=0; incoming bytes are ignored; outputs hold.
- S_ERROR: o_ready=0; o_mcu_reset=1; o_error held.
- i_reload (any state):
  - Next state S_IDLE; o_mcu_reset<=1; o_done<=0; o_error<=0; o_busy<=0; o_imem_we<=0.
  - Takes priority over a simultaneous byte transfer; that byte is dropped.
- o_ready is 1 in S_IDLE..S_CHECK, except on the cycle following i_reload, which is S_IDLE and already ready.
- Back-to-back bytes (i_valid held high) are accepted every cycle. No stall states.
- Asynchronous Reset mid-frame: immediate return to reset values. Memory contents already written are not cleared.
- o_mcu_resetPC keeps the last latched A through reload until the next frame's S_ADDR.

Test Plan:
- Reset low 100 ns, then high: o_mcu_reset=1, o_ready=1, o_done=0. Send A5,10,03,11,22,33,9A -> writes (0x10,0x11),(0x11,0x22),(0x12,0x33) on three consecutive cycles; o_mcu_reset falls, o_done=1, o_mcu_resetPC=0x10.
- Same frame with checksum 0x9B -> no release, o_error=1, o_mcu_reset=1, o_ready=0. Pulse i_reload -> o_error=0, S_IDLE, ready for a new frame.
- Bytes 00,FF,A5 then A=FE, N=03, data 01,02,03, C=FA -> addresses 0xFE,0xFF,0x00 (wrap); o_done=1.
- N=00 with 256 data bytes of 0x01, C=00 -> 256 writes; o_done asserts only after the checksum byte.
- i_reload on the same cycle as the 2nd data byte of a 3-byte frame -> that byte is not written, state S_IDLE, o_mcu_reset=1; a following valid frame loads correctly.
- Reset low mid-S_DATA -> outputs at reset values immediately (asynchronous), o_imem_we=0; after release, a full frame completes normally. i_valid toggling between bytes still yields correct writes and sum.
